// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcode/funct constants, control-field
// encodings, the packed control bundle carried on out_ctrl, and the NOP bundle.
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;

  localparam logic [2:0] F3_PRIV    = 3'b000;
  localparam logic [2:0] F3_CSR_RSV = 3'b100;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_func_e;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } br_type_e;

  typedef enum logic [2:0] {
    LD_NONE, LD_B, LD_H, LD_W, LD_BU, LD_HU
  } load_type_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z
  } imm_type_e;

  typedef enum logic [1:0] {
    OP1_RS1, OP1_PC, OP1_ZERO
  } op1_src_e;

  // Field order is MSB first; offsets below follow this order.
  typedef struct packed {
    logic       jump;
    logic       jalr;
    br_type_e   br_type;
    alu_func_e  alu_func;
    op1_src_e   op1_src;
    logic       op2_src;        // 1 = immediate, 0 = rs2
    load_type_e load_type;
    logic       cache_read_en;
    logic [3:0] cache_write_en; // byte strobes
    logic       reg_write_en;
    imm_type_e  imm_type;
    logic       csr_write_en;
  } ctrl_t;

  localparam int CTRL_W        = $bits(ctrl_t);
  localparam int OFS_CSR_WE    = 0;
  localparam int OFS_IMM_TYPE  = 1;
  localparam int OFS_REG_WE    = 4;
  localparam int OFS_CACHE_WE  = 5;
  localparam int OFS_CACHE_RE  = 9;
  localparam int OFS_LOAD_TYPE = 10;
  localparam int OFS_OP2_SRC   = 13;
  localparam int OFS_OP1_SRC   = 14;
  localparam int OFS_ALU_FUNC  = 16;
  localparam int OFS_BR_TYPE   = 20;
  localparam int OFS_JALR      = 23;
  localparam int OFS_JUMP      = 24;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam ctrl_t NOP_CTRL = '{
    jump: 1'b0, jalr: 1'b0, br_type: BR_NONE, alu_func: ALU_ADD,
    op1_src: OP1_RS1, op2_src: 1'b1, load_type: LD_NONE,
    cache_read_en: 1'b0, cache_write_en: 4'b0000, reg_write_en: 1'b0,
    imm_type: IMM_I, csr_write_en: 1'b0
  };

  // alt selects SUB for funct3=000 and SRA for funct3=101.
  function automatic alu_func_e alu_decode(input logic [2:0] f3, input logic alt);
    alu_func_e res;
    case (f3)
      F3_ADD:  res = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  res = ALU_SLL;
      F3_SLT:  res = ALU_SLT;
      F3_SLTU: res = ALU_SLTU;
      F3_XOR:  res = ALU_XOR;
      F3_SR:   res = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   res = ALU_OR;
      default: res = ALU_AND;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I instruction decoder.
// Optional macro RV32M_EN enables M-extension (funct7=0x01) decode.
// Ports: inst (in, 32) -> ctrl (control bundle), illegal, md_en, md_op.
// Illegal encodings always produce NOP_CTRL (no writes, no branch).
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        md_en,
  output logic [2:0]  md_op
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  ctrl_t      dec;
  logic       bad;
  logic       md;
  logic       unused_regs;

  assign opcode      = inst[6:0];
  assign funct3      = inst[14:12];
  assign funct7      = inst[31:25];
  assign unused_regs = ^{inst[24:15], inst[11:7]};

  always_comb begin
    dec = '0;
    bad = 1'b0;
    md  = 1'b0;
    case (opcode)
      OP_LUI: begin
        dec.reg_write_en = 1'b1;
        dec.op1_src      = OP1_ZERO;
        dec.op2_src      = 1'b1;
        dec.imm_type     = IMM_U;
      end
      OP_AUIPC: begin
        dec.reg_write_en = 1'b1;
        dec.op1_src      = OP1_PC;
        dec.op2_src      = 1'b1;
        dec.imm_type     = IMM_U;
      end
      OP_JAL: begin
        dec.jump         = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.op1_src      = OP1_PC;
        dec.op2_src      = 1'b1;
        dec.imm_type     = IMM_J;
      end
      OP_JALR: begin
        dec.jalr         = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.op2_src      = 1'b1;
        dec.imm_type     = IMM_I;
      end
      OP_BRANCH: begin
        dec.alu_func = ALU_SUB;
        dec.imm_type = IMM_B;
        case (funct3)
          F3_BEQ:  dec.br_type = BR_EQ;
          F3_BNE:  dec.br_type = BR_NE;
          F3_BLT:  dec.br_type = BR_LT;
          F3_BGE:  dec.br_type = BR_GE;
          F3_BLTU: dec.br_type = BR_LTU;
          F3_BGEU: dec.br_type = BR_GEU;
          default: bad = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec.reg_write_en  = 1'b1;
        dec.cache_read_en = 1'b1;
        dec.op2_src       = 1'b1;
        dec.imm_type      = IMM_I;
        case (funct3)
          F3_LB:   dec.load_type = LD_B;
          F3_LH:   dec.load_type = LD_H;
          F3_LW:   dec.load_type = LD_W;
          F3_LBU:  dec.load_type = LD_BU;
          F3_LHU:  dec.load_type = LD_HU;
          default: bad = 1'b1;
        endcase
      end
      OP_STORE: begin
        dec.op2_src  = 1'b1;
        dec.imm_type = IMM_S;
        case (funct3)
          F3_SB:   dec.cache_write_en = 4'b0001;
          F3_SH:   dec.cache_write_en = 4'b0011;
          F3_SW:   dec.cache_write_en = 4'b1111;
          default: bad = 1'b1;
        endcase
      end
      OP_IMM: begin
        dec.reg_write_en = 1'b1;
        dec.op2_src      = 1'b1;
        dec.imm_type     = IMM_I;
        dec.alu_func     = alu_decode(funct3, (funct3 == F3_SR) && (funct7 == F7_ALT));
        // funct7 is only an opcode field for the shift-immediates
        if ((funct3 == F3_SLL || funct3 == F3_SR) &&
            funct7 != F7_BASE && funct7 != F7_ALT)
          bad = 1'b1;
      end
      OP_REG: begin
        dec.reg_write_en = 1'b1;
        if (funct7 == F7_BASE || funct7 == F7_ALT)
          dec.alu_func = alu_decode(funct3, funct7 == F7_ALT);
`ifdef RV32M_EN
        else if (funct7 == F7_MULDIV)
          md = 1'b1;
`endif
        else
          bad = 1'b1;
      end
      OP_SYSTEM: begin
        if (funct3 == F3_PRIV || funct3 == F3_CSR_RSV) begin
          bad = 1'b1;
        end else begin
          dec.csr_write_en = 1'b1;
          dec.reg_write_en = 1'b1;
          if (funct3[2])
            dec.imm_type = IMM_Z;
          else
            dec.imm_type = IMM_NONE;
        end
      end
      default: bad = 1'b1;
    endcase
  end

  assign ctrl    = bad ? NOP_CTRL : dec;
  assign illegal = bad;
  assign md_en   = md && !bad;
  assign md_op   = md_en ? funct3 : 3'b000;

endmodule

// File: rtl/id_decode_stage.sv
// Registered RV32I decode stage: decodes in_inst and carries the control
// bundle with its PC through a 2-entry skid buffer (valid/ready both sides).
// Optional macro RV32M_EN (via decode_comb) enables M-extension decode.
// Ports:
//   clk, rst_n (async active-low), flush
//   in_valid/in_ready/in_inst/in_pc          upstream handshake
//   out_valid/out_ready/out_pc/out_inst      head entry
//   out_ctrl (CTRL_W), out_illegal, out_md_en, out_md_op
//   ill_count  saturating count of accepted illegal instructions
module id_decode_stage
  import decode_pkg::*;
#(
  parameter int PC_W           = 32,
  parameter int ILL_CNT_W      = 16,
  parameter bit ILLEGAL_AS_NOP = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [PC_W-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [31:0]          out_inst,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic                 out_illegal,
  output logic                 out_md_en,
  output logic [2:0]           out_md_op,
  output logic [ILL_CNT_W-1:0] ill_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
    ctrl_t           ctrl;
    logic            illegal;
    logic            md_en;
    logic [2:0]      md_op;
  } entry_t;

  buf_state_e state, next_state;
  entry_t     head, tail, new_entry;
  ctrl_t      dec_ctrl;
  logic       dec_illegal, dec_md_en;
  logic [2:0] dec_md_op;
  logic       push, pop;
  logic       load_head_new, load_head_tail, load_tail;

  decode_comb u_decode_comb (
    .inst    (in_inst),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .md_en   (dec_md_en),
    .md_op   (dec_md_op)
  );

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    new_entry.pc      = in_pc;
    new_entry.inst    = (dec_illegal && ILLEGAL_AS_NOP) ? NOP_INST : in_inst;
    new_entry.ctrl    = dec_ctrl;
    new_entry.illegal = dec_illegal && !ILLEGAL_AS_NOP;
    new_entry.md_en   = dec_md_en;
    new_entry.md_op   = dec_md_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= next_state;
  end

  // head is always the output entry; tail only holds the skid entry in TWO.
  always_comb begin
    next_state     = state;
    load_head_new  = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            next_state    = ONE;
            load_head_new = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            load_head_new = 1'b1;
          end else if (push) begin
            next_state = TWO;
            load_tail  = 1'b1;
          end else if (pop) begin
            next_state = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            next_state     = ONE;
            load_head_tail = 1'b1;
          end
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (load_head_new)       head <= new_entry;
      else if (load_head_tail) head <= tail;
      if (load_tail)           tail <= new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ill_count <= '0;
    else if (push && dec_illegal && ill_count != '1)
      ill_count <= ill_count + 1'b1;
  end

  assign out_pc      = head.pc;
  assign out_inst    = head.inst;
  assign out_ctrl    = head.ctrl;
  assign out_illegal = head.illegal;
  assign out_md_en   = head.md_en;
  assign out_md_op   = head.md_op;

endmodule

// File: tb/tb_id_decode_stage.sv
module tb_id_decode_stage;
  import decode_pkg::*;

  localparam int PC_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [31:0]       in_inst = '0;
  logic [PC_W-1:0]   in_pc = '0;

  logic              a_in_ready, a_out_valid, a_illegal, a_md_en;
  logic [PC_W-1:0]   a_pc;
  logic [31:0]       a_inst;
  logic [CTRL_W-1:0] a_ctrl;
  logic [2:0]        a_md_op;
  logic [15:0]       a_cnt;

  logic              n_in_ready, n_out_valid, n_illegal, n_md_en;
  logic [PC_W-1:0]   n_pc;
  logic [31:0]       n_inst;
  logic [CTRL_W-1:0] n_ctrl;
  logic [2:0]        n_md_op;
  logic [15:0]       n_cnt;

  logic              s_in_ready, s_out_valid, s_illegal, s_md_en;
  logic [PC_W-1:0]   s_pc;
  logic [31:0]       s_inst;
  logic [CTRL_W-1:0] s_ctrl;
  logic [2:0]        s_md_op;
  logic [1:0]        s_cnt;

  id_decode_stage #(.PC_W(PC_W), .ILL_CNT_W(16), .ILLEGAL_AS_NOP(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_inst(a_inst), .out_ctrl(a_ctrl), .out_illegal(a_illegal),
    .out_md_en(a_md_en), .out_md_op(a_md_op), .ill_count(a_cnt));

  id_decode_stage #(.PC_W(PC_W), .ILL_CNT_W(16), .ILLEGAL_AS_NOP(1'b1)) dut_nop (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_pc(n_pc), .out_inst(n_inst), .out_ctrl(n_ctrl), .out_illegal(n_illegal),
    .out_md_en(n_md_en), .out_md_op(n_md_op), .ill_count(n_cnt));

  id_decode_stage #(.PC_W(PC_W), .ILL_CNT_W(2), .ILLEGAL_AS_NOP(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_pc), .out_inst(s_inst), .out_ctrl(s_ctrl), .out_illegal(s_illegal),
    .out_md_en(s_md_en), .out_md_op(s_md_op), .ill_count(s_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_ill = 0;

  typedef struct {
    logic [31:0] inst;
    ctrl_t       ctrl;
    logic        ill;
    logic        md_en;
    logic [2:0]  md_op;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic ctrl_t mk(input logic jump, input logic jalr, input br_type_e br,
                               input alu_func_e alu, input op1_src_e op1, input logic op2,
                               input load_type_e ld, input logic crd, input logic [3:0] cwr,
                               input logic rw, input imm_type_e imm, input logic csr);
    ctrl_t c;
    c.jump = jump; c.jalr = jalr; c.br_type = br; c.alu_func = alu;
    c.op1_src = op1; c.op2_src = op2; c.load_type = ld; c.cache_read_en = crd;
    c.cache_write_en = cwr; c.reg_write_en = rw; c.imm_type = imm; c.csr_write_en = csr;
    return c;
  endfunction

  task automatic add(input logic [31:0] inst, input ctrl_t c, input logic ill,
                     input logic md_en, input logic [2:0] md_op);
    vec_t v;
    v.inst = inst; v.ctrl = c; v.ill = ill; v.md_en = md_en; v.md_op = md_op;
    vecs.push_back(v);
  endtask

  function automatic logic [1:0] sat2(input int n);
    return (n > 3) ? 2'd3 : n[1:0];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    ctrl_t nopc;
    nopc = mk(0, 0, BR_NONE, ALU_ADD, OP1_RS1, 1, LD_NONE, 0, 4'b0000, 0, IMM_I, 0);

    add(32'h00500093, mk(0, 0, BR_NONE, ALU_ADD, OP1_RS1, 1, LD_NONE, 0, 4'b0000, 1, IMM_I, 0), 0, 0, 0); // addi
    add(32'h00112223, mk(0, 0, BR_NONE, ALU_ADD, OP1_RS1, 1, LD_NONE, 0, 4'b1111, 0, IMM_S, 0), 0, 0, 0); // sw
    add(32'h00812283, mk(0, 0, BR_NONE, ALU_ADD, OP1_RS1, 1, LD_W,    1, 4'b0000, 1, IMM_I, 0), 0, 0, 0); // lw
    add(32'h402081B3, mk(0, 0, BR_NONE, ALU_SUB, OP1_RS1, 0, LD_NONE, 0, 4'b0000, 1, IMM_NONE, 0), 0, 0, 0); // sub
    add(32'h00208463, mk(0, 0, BR_EQ,   ALU_SUB, OP1_RS1, 0, LD_NONE, 0, 4'b0000, 0, IMM_B, 0), 0, 0, 0); // beq
    add(32'h123452B7, mk(0, 0, BR_NONE, ALU_ADD, OP1_ZERO, 1, LD_NONE, 0, 4'b0000, 1, IMM_U, 0), 0, 0, 0); // lui
    add(32'h000000EF, mk(1, 0, BR_NONE, ALU_ADD, OP1_PC,  1, LD_NONE, 0, 4'b0000, 1, IMM_J, 0), 0, 0, 0); // jal
    add(32'h300110F3, mk(0, 0, BR_NONE, ALU_ADD, OP1_RS1, 0, LD_NONE, 0, 4'b0000, 1, IMM_NONE, 1), 0, 0, 0); // csrrw
    add(32'h00008067, mk(0, 1, BR_NONE, ALU_ADD, OP1_RS1, 1, LD_NONE, 0, 4'b0000, 1, IMM_I, 0), 0, 0, 0); // jalr
    add(32'h4030D093, mk(0, 0, BR_NONE, ALU_SRA, OP1_RS1, 1, LD_NONE, 0, 4'b0000, 1, IMM_I, 0), 0, 0, 0); // srai
    add(32'h00002063, nopc, 1, 0, 0); // branch funct3=010
    add(32'hFFFFFFFF, nopc, 1, 0, 0);
    add(32'h00000000, nopc, 1, 0, 0);
    add(32'h00000073, nopc, 1, 0, 0); // ecall (CSR funct3=000)
    add(32'h80000033, nopc, 1, 0, 0); // R-type funct7=0x40
`ifdef RV32M_EN
    add(32'h022081B3, mk(0, 0, BR_NONE, ALU_ADD, OP1_RS1, 0, LD_NONE, 0, 4'b0000, 1, IMM_NONE, 0), 0, 1, 3'd0); // mul
`else
    add(32'h022081B3, nopc, 1, 0, 0); // mul without M
`endif
    add(32'h00110023, mk(0, 0, BR_NONE, ALU_ADD, OP1_RS1, 1, LD_NONE, 0, 4'b0001, 0, IMM_S, 0), 0, 0, 0); // sb
    add(32'h00001097, mk(0, 0, BR_NONE, ALU_ADD, OP1_PC,  1, LD_NONE, 0, 4'b0000, 1, IMM_U, 0), 0, 0, 0); // auipc
    add(32'h3002E0F3, mk(0, 0, BR_NONE, ALU_ADD, OP1_RS1, 0, LD_NONE, 0, 4'b0000, 1, IMM_Z, 1), 0, 0, 0); // csrrsi
    add(32'h0020E063, mk(0, 0, BR_LTU,  ALU_SUB, OP1_RS1, 0, LD_NONE, 0, 4'b0000, 0, IMM_B, 0), 0, 0, 0); // bltu
    add(32'h00015083, mk(0, 0, BR_NONE, ALU_ADD, OP1_RS1, 1, LD_HU,   1, 4'b0000, 1, IMM_I, 0), 0, 0, 0); // lhu

    // Reset state, observed before any clock edge while rst_n is low
    #2;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_ctrl", a_ctrl, 0);
    chk("rst_out_pc", a_pc, 0);
    chk("rst_out_inst", a_inst, 0);
    chk("rst_out_illegal", a_illegal, 0);
    chk("rst_md", {a_md_en, a_md_op}, 0);
    chk("rst_ill_count", a_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", a_in_ready, 1);

    // Table: one instruction per cycle, out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_inst  = vecs[i].inst;
      in_pc    = 32'h100 + 32'(i) * 4;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (vecs[i].ill) exp_ill++;
      chk($sformatf("v%0d_out_valid", i), a_out_valid, 1);
      chk($sformatf("v%0d_ctrl", i), a_ctrl, vecs[i].ctrl);
      chk($sformatf("v%0d_illegal", i), a_illegal, vecs[i].ill);
      chk($sformatf("v%0d_md", i), {a_md_en, a_md_op}, {vecs[i].md_en, vecs[i].md_op});
      chk($sformatf("v%0d_pc", i), a_pc, 32'h100 + 32'(i) * 4);
      chk($sformatf("v%0d_inst", i), a_inst, vecs[i].inst);
      chk($sformatf("v%0d_ill_count", i), a_cnt, exp_ill);
      chk($sformatf("v%0d_nop_illegal", i), n_illegal, 0);
      chk($sformatf("v%0d_nop_ctrl", i), n_ctrl, vecs[i].ctrl);
      chk($sformatf("v%0d_nop_inst", i), n_inst, vecs[i].ill ? 32'h00000013 : vecs[i].inst);
      chk($sformatf("v%0d_nop_ill_count", i), n_cnt, exp_ill);
      chk($sformatf("v%0d_sat_count", i), s_cnt, sat2(exp_ill));
    end
    @(posedge clk);
    #1;
    chk("drain_out_valid", a_out_valid, 0);

    // Backpressure: two accepted, third stalls, order preserved
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h200;
    @(posedge clk);
    #1;
    chk("bp_ready_one", a_in_ready, 1);
    chk("bp_head_a", a_inst, 32'h00500093);
    @(negedge clk);
    in_inst = 32'h00112223; in_pc = 32'h204;
    @(posedge clk);
    #1;
    chk("bp_ready_two", a_in_ready, 0);
    chk("bp_hold_a", a_inst, 32'h00500093);
    @(negedge clk);
    in_inst = 32'h022081B3; in_pc = 32'h208;
    @(posedge clk);
    #1;
    chk("bp_stall_ready", a_in_ready, 0);
    chk("bp_stall_valid", a_out_valid, 1);
    chk("bp_stall_pc", a_pc, 32'h200);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_head_b", a_inst, 32'h00112223);
    chk("bp_head_b_pc", a_pc, 32'h204);
    chk("bp_ready_after_pop", a_in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
`ifndef RV32M_EN
    exp_ill++;
`endif
    chk("bp_head_c", a_inst, 32'h022081B3);
    chk("bp_head_c_pc", a_pc, 32'h208);
    chk("bp_ill_count", a_cnt, exp_ill);
    @(posedge clk);
    #1;
    chk("bp_empty", a_out_valid, 0);

    // Flush from TWO with a same-cycle illegal input
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h300;
    @(posedge clk);
    #1;
    @(negedge clk);
    in_inst = 32'h00812283; in_pc = 32'h304;
    @(posedge clk);
    #1;
    chk("fl_two_ready", a_in_ready, 0);
    @(negedge clk);
    flush = 1'b1; in_inst = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_two_valid", a_out_valid, 0);
    chk("fl_two_ready_after", a_in_ready, 1);
    chk("fl_two_ill_count", a_cnt, exp_ill);

    // Flush from ONE: in_ready is high, so the illegal input would be accepted without flush
    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h310;
    @(posedge clk);
    #1;
    chk("fl_one_valid_before", a_out_valid, 1);
    @(negedge clk);
    flush = 1'b1; in_inst = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_one_valid", a_out_valid, 0);
    chk("fl_one_ill_count", a_cnt, exp_ill);

    // Asynchronous reset between clock edges
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h400;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("ar_valid_before", a_out_valid, 1);
    #2;
    rst_n = 1'b0;
    exp_ill = 0;
    #1;
    chk("ar_valid", a_out_valid, 0);
    chk("ar_inst", a_inst, 0);
    chk("ar_ctrl", a_ctrl, 0);
    chk("ar_pc", a_pc, 0);
    chk("ar_ill_count", a_cnt, 0);
    chk("ar_sat_count", s_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'h00812283; in_pc = 32'h500;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("ar_push_valid", a_out_valid, 1);
    chk("ar_push_inst", a_inst, 32'h00812283);
    chk("ar_push_pc", a_pc, 32'h500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
